// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and spi_master-side signals around spi_req_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_WIDTH  = 2
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*SLV_WIDTH-1:0]  req_slv;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          err;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         m_data_send;
    logic                          m_spi_start;
    logic                          m_spi_done;
    logic [DATA_WIDTH-1:0]         m_data_recv;
    logic                          m_csn;
    logic [NUM_SLAVES-1:0]         cs_n;

    modport slave (
        input  req, req_data, req_slv, m_spi_done, m_data_recv, m_csn,
        output gnt, ack, err, rdata, busy, m_data_send, m_spi_start, cs_n
    );

    modport master (
        output req, req_data, req_slv, m_spi_done, m_data_recv, m_csn,
        input  gnt, ack, err, rdata, busy, m_data_send, m_spi_start, cs_n
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among several requesters, with
// chip-select steering, invalid-slave rejection and a WAIT watchdog.
module spi_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_WIDTH  = 2,
    parameter int TIMEOUT    = 1023
) (
    input logic              clk,
    input logic              arstn,
    spi_req_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t                state, state_d;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic [DATA_WIDTH-1:0] win_data;
    logic [SLV_WIDTH-1:0]  win_slv;
    logic                  win_valid;
    logic [WD_W-1:0]       wd;
    logic [SLV_WIDTH-1:0]  sel;
    logic                  active;
    logic [NUM_REQ-1:0]    gnt;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] m_data_send;
    logic [NUM_SLAVES-1:0] cs_n;

    // First requester at or after ptr, searching upward with wrap-around.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sum    = '0;
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_slv  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (PTR_W'(r) == winner) begin
                win_data = bus.req_data[r*DATA_WIDTH +: DATA_WIDTH];
                win_slv  = bus.req_slv[r*SLV_WIDTH +: SLV_WIDTH];
            end
        end
    end

    assign win_valid = int'(win_slv) < NUM_SLAVES;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found) state_d = win_valid ? START : RESP;
            START:   state_d = WAIT;
            WAIT:    if (bus.m_spi_done || wd == WD_MAX) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr         <= '0;
            wd          <= '0;
            sel         <= '0;
            active      <= 1'b0;
            gnt         <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            m_data_send <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt <= NUM_REQ'(1) << winner;
                        ptr <= (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
                        sel <= win_slv;
                        if (win_valid) begin
                            m_data_send <= win_data;
                            active      <= 1'b1;
                        end else begin
                            // Unaddressable slave: answer at once, never start the master.
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                START: wd <= '0;
                WAIT: begin
                    if (bus.m_spi_done) begin
                        rdata <= bus.m_data_recv;
                        err   <= 1'b0;
                    end else if (wd == WD_MAX) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                RESP: begin
                    gnt    <= '0;
                    active <= 1'b0;
                    err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Only the selected line follows the master; active drops on reset directly.
    always_comb begin
        cs_n = '1;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (active && int'(sel) == k) cs_n[k] = bus.m_csn;
        end
    end

    assign bus.cs_n        = cs_n;
    assign bus.gnt         = gnt;
    assign bus.ack         = (state == RESP) ? gnt : '0;
    assign bus.err         = err;
    assign bus.rdata       = rdata;
    assign bus.busy        = (state != IDLE);
    assign bus.m_data_send = m_data_send;
    assign bus.m_spi_start = (state == START);
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed scenarios then random
// transfers, with the bench acting as spi_master and keeping its own rr pointer.
module tb_spi_req_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_WIDTH(SW)) bus ();

    spi_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int m_ptr = 0;
    logic [DW-1:0] rdat [NR];
    logic [SW-1:0] rslv [NR];

    always @(negedge clk) if (bus.m_spi_start === 1'b1) start_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i*DW +: DW] = rdat[i];
            bus.req_slv[i*SW +: SW]  = rslv[i];
        end
    endtask

    function automatic int model_winner(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++)
            if (r[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        return -1;
    endfunction

    function automatic logic [NS-1:0] cs_exp(input int s);
        logic [NS-1:0] m;
        m = '1;
        m[s] = 1'b0;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        arstn = 1'b0;
        bus.req = '0;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
    endtask

    // Entered at a negedge in an IDLE cycle with req already driven; leaves at
    // the negedge of the IDLE cycle that follows RESP. delay<0 means done never comes.
    task automatic run_txn(input string tag, input int delay, input logic [DW-1:0] resp,
                           input bit drop, output int w);
        int  s;
        int  n;
        int  st0;
        bit  valid;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        pack_inputs();
        w     = model_winner(bus.req);
        s     = int'(rslv[w]);
        valid = (s < NS);
        m_ptr = (w + 1) % NR;
        st0   = start_cnt;
        @(negedge clk);
        check({tag, "_gnt"}, bus.gnt, 32'(1) << w);
        check({tag, "_busy"}, bus.busy, 1);
        if (valid) begin
            check({tag, "_start"}, bus.m_spi_start, 1);
            check({tag, "_mdata"}, bus.m_data_send, rdat[w]);
            if (drop) bus.req[w] = 1'b0;
            bus.m_csn = 1'b0;
            #1 check({tag, "_cs_sel"}, bus.cs_n, cs_exp(s));
            if (delay < 0) begin
                n = 0;
                while (bus.ack === '0 && n < TMO + 10) begin
                    @(negedge clk);
                    n++;
                end
                check({tag, "_tmo_lat"}, n, TMO + 2);
                exp_rdata = '0;
                exp_err   = 1'b1;
            end else begin
                for (int d = 0; d < delay; d++) begin
                    @(negedge clk);
                    check({tag, "_ack_early"}, bus.ack, 0);
                end
                @(negedge clk);
                bus.m_spi_done  = 1'b1;
                bus.m_data_recv = resp;
                @(negedge clk);
                bus.m_spi_done  = 1'b0;
                bus.m_data_recv = '0;
                exp_rdata = resp;
                exp_err   = 1'b0;
            end
            bus.m_csn = 1'b1;
        end else begin
            exp_rdata = '0;
            exp_err   = 1'b1;
            check({tag, "_nostart"}, bus.m_spi_start, 0);
            bus.m_csn = 1'b0;
            #1 check({tag, "_cs_idle"}, bus.cs_n, {NS{1'b1}});
            bus.m_csn = 1'b1;
        end
        check({tag, "_ack"}, bus.ack, 32'(1) << w);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_rdata"}, bus.rdata, exp_rdata);
        check({tag, "_starts"}, start_cnt, st0 + (valid ? 1 : 0));
        @(negedge clk);
        check({tag, "_ack_off"}, bus.ack, 0);
        check({tag, "_gnt_off"}, bus.gnt, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int w;
        bus.req         = '0;
        bus.req_data    = '0;
        bus.req_slv     = '0;
        bus.m_spi_done  = 1'b0;
        bus.m_data_recv = '0;
        bus.m_csn       = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rdat[i] = '0;
            rslv[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mdata", bus.m_data_send, 0);
        check("rst_start", bus.m_spi_start, 0);
        check("rst_cs", bus.cs_n, {NS{1'b1}});
        arstn = 1'b1;
        bus.m_csn = 1'b1;
        @(negedge clk);

        // Basic transfer to slave 2, master returns 3C.
        rdat[0] = 8'hA5;
        rslv[0] = 2'd2;
        bus.req = 4'b0001;
        run_txn("basic", 2, 8'h3C, 1'b0, w);

        // Round robin with all requesters held, then a sparse pattern.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            rdat[i] = 8'(8'h10 + i);
            rslv[i] = SW'(i % NS);
        end
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            run_txn("rr_all", 1, 8'(8'h40 + i), 1'b0, w);
            check("rr_all_order", w, i);
        end
        bus.req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_txn("rr_1001", 0, 8'(8'h80 + i), 1'b0, w);
            check("rr_1001_order", w, (i % 2 == 0) ? 0 : 3);
        end

        // Unaddressable slave index.
        rslv[1] = 2'd3;
        bus.req = 4'b0010;
        run_txn("badslv", 0, 8'h00, 1'b0, w);
        rslv[1] = 2'd0;

        // Watchdog expiry, then normal service resumes.
        rslv[2] = 2'd1;
        bus.req = 4'b0100;
        run_txn("timeout", -1, 8'h00, 1'b0, w);
        run_txn("after_tmo", 1, 8'h5A, 1'b0, w);
        // Done arriving in the very cycle the watchdog fires must win.
        run_txn("coincide", TMO, 8'hC3, 1'b0, w);

        // Requester drops req right after its grant; transfer still completes.
        run_txn("drop", 1, 8'h77, 1'b1, w);
        check("drop_who", w, 2);

        // Reset in the middle of WAIT.
        rslv[1] = 2'd0;
        pack_inputs();
        bus.req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        bus.m_csn = 1'b0;
        #1 check("wrst_cs_before", bus.cs_n, cs_exp(0));
        check("wrst_gnt_before", bus.gnt, 4'b0010);
        arstn = 1'b0;
        #1 check("wrst_cs", bus.cs_n, {NS{1'b1}});
        check("wrst_gnt", bus.gnt, 0);
        check("wrst_busy", bus.busy, 0);
        bus.req = '0;
        @(negedge clk);
        arstn = 1'b1;
        bus.m_csn = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        check("wrst_idle", bus.busy, 0);
        bus.req = 4'b1111;
        run_txn("wrst_ptr", 0, 8'h99, 1'b0, w);
        check("wrst_ptr_zero", w, 0);

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                rdat[i] = 8'($urandom);
                rslv[i] = SW'($urandom_range(0, 3));
            end
            bus.req = 4'($urandom_range(1, 15));
            run_txn("rand", ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)),
                    8'($urandom), 1'($urandom_range(0, 1)), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
